// File: rtl/player_motion_ctrl.sv
// Player mover: 64x fixed-point position with per-frame accel/decay, edge clamping and a life/respawn FSM.
// Build option PLAYER_Y_MOVE_EN enables vertical motion (up/down) clamped to [Y_MIN, Y_MAX].
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_ALIVE     | normal play, motion enabled, hits take a life
// ST_DYING     | frozen and invisible for DEATH_FRAMES frames after a hit
// ST_RESPAWN   | back at the start point, moving, invulnerable, blinking
// ST_GAME_OVER | no lives left, invisible, everything ignored until reset
module player_motion_ctrl #(
    parameter int INITIAL_X     = 320,
    parameter int INITIAL_Y     = 450,
    parameter int FRAC_BITS     = 6,
    parameter int MAX_SPEED     = 128,
    parameter int ACCEL         = 32,
    parameter int OBJ_W         = 32,
    parameter int FRAME_W       = 640,
    parameter int DEATH_FRAMES  = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4,
    parameter int LIVES         = 3
`ifdef PLAYER_Y_MOVE_EN
    ,
    parameter int Y_MIN         = 400,
    parameter int Y_MAX         = 450
`endif
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        right,
    input  logic        left,
    input  logic        up,
    input  logic        down,
    input  logic        plrHit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        visible,
    output logic        invulnerable,
    output logic [2:0]  livesLeft,
    output logic        gameOver
);

    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_DYING,
        ST_RESPAWN,
        ST_GAME_OVER
    } state_t;

    localparam logic signed [31:0] X_INIT  = INITIAL_X << FRAC_BITS;
    localparam logic signed [31:0] Y_INIT  = INITIAL_Y << FRAC_BITS;
    localparam logic signed [31:0] X_MAX   = (FRAME_W - OBJ_W) << FRAC_BITS;
    localparam logic signed [31:0] SPD_MAX = MAX_SPEED;
    localparam logic signed [31:0] SPD_ACC = ACCEL;
    localparam logic [15:0] DEATH_CNT  = 16'(DEATH_FRAMES);
    localparam logic [15:0] INVULN_CNT = 16'(INVULN_FRAMES);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    state_t             state_q, state_d;
    logic signed [31:0] posx_q, posx_d, posy_q, posy_d;
    logic signed [31:0] xspd_q, xspd_d, yspd_q, yspd_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        blink_q, blink_d;
    logic [2:0]         lives_q, lives_d;
    logic               visible_q, visible_d;
    logic               invuln_q, invuln_d;
    logic               gameover_q, gameover_d;

    logic signed [31:0] nx, mv_x, mv_xs, mv_y, mv_ys;

    // inc/dec are the two opposing key levels; both or neither means coast to a stop
    function automatic logic signed [31:0] step_speed(input logic signed [31:0] spd,
                                                      input logic inc, input logic dec);
        logic signed [31:0] s;
        s = '0;
        if (inc && !dec) begin
            s = spd + SPD_ACC;
            if (s > SPD_MAX) s = SPD_MAX;
        end else if (dec && !inc) begin
            s = spd - SPD_ACC;
            if (s < -SPD_MAX) s = -SPD_MAX;
        end else if (spd > SPD_ACC) begin
            s = spd - SPD_ACC;
        end else if (spd < -SPD_ACC) begin
            s = spd + SPD_ACC;
        end
        return s;
    endfunction

    always_comb begin
        nx    = posx_q + xspd_q;
        mv_x  = nx;
        mv_xs = step_speed(xspd_q, right, left);
        if (nx < 0) begin
            mv_x  = '0;
            mv_xs = '0;
        end else if (nx > X_MAX) begin
            mv_x  = X_MAX;
            mv_xs = '0;
        end
    end

`ifdef PLAYER_Y_MOVE_EN
    localparam logic signed [31:0] Y_LO = Y_MIN << FRAC_BITS;
    localparam logic signed [31:0] Y_HI = Y_MAX << FRAC_BITS;
    logic signed [31:0] ny;

    always_comb begin
        ny    = posy_q + yspd_q;
        mv_y  = ny;
        mv_ys = step_speed(yspd_q, down, up);
        if (ny < Y_LO) begin
            mv_y  = Y_LO;
            mv_ys = '0;
        end else if (ny > Y_HI) begin
            mv_y  = Y_HI;
            mv_ys = '0;
        end
    end
`else
    logic unused_yin;
    assign unused_yin = ^{up, down, yspd_q};
    assign mv_y       = Y_INIT;
    assign mv_ys      = '0;
`endif

    always_comb begin
        state_d    = state_q;
        posx_d     = posx_q;
        posy_d     = posy_q;
        xspd_d     = xspd_q;
        yspd_d     = yspd_q;
        cnt_d      = cnt_q;
        blink_d    = blink_q;
        lives_d    = lives_q;
        visible_d  = visible_q;
        invuln_d   = invuln_q;
        gameover_d = gameover_q;
        case (state_q)
            ST_ALIVE: begin
                // a hit takes priority over a coincident frame update
                if (plrHit && !invuln_q) begin
                    lives_d   = lives_q - 3'd1;
                    xspd_d    = '0;
                    yspd_d    = '0;
                    cnt_d     = DEATH_CNT;
                    visible_d = 1'b0;
                    if (lives_q == 3'd1) begin
                        state_d    = ST_GAME_OVER;
                        gameover_d = 1'b1;
                    end else begin
                        state_d = ST_DYING;
                    end
                end else if (startOfFrame) begin
                    posx_d = mv_x;
                    xspd_d = mv_xs;
                    posy_d = mv_y;
                    yspd_d = mv_ys;
                end
            end
            ST_DYING: begin
                if (startOfFrame) begin
                    if (cnt_q <= 16'd1) begin
                        state_d   = ST_RESPAWN;
                        posx_d    = X_INIT;
                        posy_d    = Y_INIT;
                        xspd_d    = '0;
                        yspd_d    = '0;
                        cnt_d     = INVULN_CNT;
                        blink_d   = '0;
                        visible_d = 1'b1;
                        invuln_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            ST_RESPAWN: begin
                if (startOfFrame) begin
                    posx_d = mv_x;
                    xspd_d = mv_xs;
                    posy_d = mv_y;
                    yspd_d = mv_ys;
                    if (cnt_q <= 16'd1) begin
                        state_d   = ST_ALIVE;
                        visible_d = 1'b1;
                        invuln_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                        if (blink_q == BLINK_LAST) begin
                            blink_d   = '0;
                            visible_d = !visible_q;
                        end else begin
                            blink_d = blink_q + 16'd1;
                        end
                    end
                end
            end
            ST_GAME_OVER: begin
            end
            default: state_d = ST_ALIVE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_ALIVE;
            posx_q     <= X_INIT;
            posy_q     <= Y_INIT;
            xspd_q     <= '0;
            yspd_q     <= '0;
            cnt_q      <= '0;
            blink_q    <= '0;
            lives_q    <= LIVES_INIT;
            visible_q  <= 1'b1;
            invuln_q   <= 1'b0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            posx_q     <= posx_d;
            posy_q     <= posy_d;
            xspd_q     <= xspd_d;
            yspd_q     <= yspd_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            lives_q    <= lives_d;
            visible_q  <= visible_d;
            invuln_q   <= invuln_d;
            gameover_q <= gameover_d;
        end
    end

    assign topLeftX     = posx_q[FRAC_BITS +: 11];
    assign topLeftY     = posy_q[FRAC_BITS +: 11];
    assign visible      = visible_q;
    assign invulnerable = invuln_q;
    assign livesLeft    = lives_q;
    assign gameOver     = gameover_q;

endmodule
